// File: rtl/cqe_write_engine_if.sv
// Bundle of the CQ offset response, CQE payload, context write, DMA write and
// completion event channels seen by one cqe_write_engine instance.
interface cqe_write_engine_if #(
   parameter int CQ_NUM_LOG = 12,
   parameter int CQE_WIDTH  = 256
) ();
   // Every channel: a transfer happens on a rising clk edge where valid && ready;
   // the source holds valid and its payload steady until that edge.
   logic                  cq_resp_valid;
   logic [55:0]           cq_resp_head;
   logic                  cq_resp_ready;
   logic                  cqe_data_valid;
   logic [CQE_WIDTH-1:0]  cqe_data;
   logic                  cqe_data_ready;
   logic                  ctx_wr_en;
   logic [CQ_NUM_LOG-1:0] ctx_wr_cqn;
   logic [64:0]           ctx_wr_data;
   logic                  dma_wr_req_valid;
   logic [127:0]          dma_wr_req_head;
   logic [CQE_WIDTH-1:0]  dma_wr_req_data;
   logic                  dma_wr_req_ready;
   logic                  cq_event_valid;
   logic [CQ_NUM_LOG-1:0] cq_event_cqn;
   logic                  cq_event_ready;

   modport master (
      input  cq_resp_valid, cq_resp_head, cqe_data_valid, cqe_data,
             ctx_wr_en, ctx_wr_cqn, ctx_wr_data, dma_wr_req_ready, cq_event_ready,
      output cq_resp_ready, cqe_data_ready, dma_wr_req_valid, dma_wr_req_head,
             dma_wr_req_data, cq_event_valid, cq_event_cqn
   );

   modport slave (
      output cq_resp_valid, cq_resp_head, cqe_data_valid, cqe_data,
             ctx_wr_en, ctx_wr_cqn, ctx_wr_data, dma_wr_req_ready, cq_event_ready,
      input  cq_resp_ready, cqe_data_ready, dma_wr_req_valid, dma_wr_req_head,
             dma_wr_req_data, cq_event_valid, cq_event_cqn
   );
endinterface

// File: rtl/cqe_write_engine.sv
// Pairs each CQ offset response with its CQE payload, looks up the CQ base in the
// context table, issues one DMA write at base + offset and optionally an event.
module cqe_write_engine #(
   parameter int CQ_NUM_LOG = 12,
   parameter int CQE_LENGTH = 32,
   parameter int CQE_WIDTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   cqe_write_engine_if.master    eng_io,
   output logic [2:0]            state_o
);
   localparam logic [2:0] IDLE_s      = 3'd0;
   localparam logic [2:0] LOOKUP_s    = 3'd1;
   localparam logic [2:0] WAIT_DATA_s = 3'd2;
   localparam logic [2:0] DMA_s       = 3'd3;
   localparam logic [2:0] EVENT_s     = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [CQ_NUM_LOG-1:0] cqn_q;
   logic [23:0]           offset_q;
   logic [63:0]           base_q;
   logic                  event_en_q;
   logic [CQE_WIDTH-1:0]  cqe_q;
   logic [63:0]           addr_q;

   logic [64:0]           ctx_mem_q [0:(1<<CQ_NUM_LOG)-1];
   logic [64:0]           ctx_rd_q;
   logic [CQ_NUM_LOG-1:0] ctx_rd_addr;

   logic resp_hs, data_hs, dma_hs, event_hs;
   logic unused_cqn_hi;

   assign resp_hs  = eng_io.cq_resp_valid    && eng_io.cq_resp_ready;
   assign data_hs  = eng_io.cqe_data_valid   && eng_io.cqe_data_ready;
   assign dma_hs   = eng_io.dma_wr_req_valid && eng_io.dma_wr_req_ready;
   assign event_hs = eng_io.cq_event_valid   && eng_io.cq_event_ready;

   // Only the low CQ_NUM_LOG bits of the 32-bit CQN index the table.
   assign ctx_rd_addr   = eng_io.cq_resp_head[CQ_NUM_LOG-1:0];
   assign unused_cqn_hi = ^eng_io.cq_resp_head[31:CQ_NUM_LOG];
   assign state_o       = state_q;

   // Read-before-write: a same-address read and write returns the old entry.
   always_ff @(posedge clk) begin
      if (eng_io.ctx_wr_en) begin
         ctx_mem_q[eng_io.ctx_wr_cqn] <= eng_io.ctx_wr_data;
      end
      ctx_rd_q <= ctx_mem_q[ctx_rd_addr];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE_s:      if (resp_hs) state_d = LOOKUP_s;
         LOOKUP_s:    state_d = WAIT_DATA_s;
         WAIT_DATA_s: if (data_hs) state_d = DMA_s;
         DMA_s:       if (dma_hs) state_d = event_en_q ? EVENT_s : IDLE_s;
         EVENT_s:     if (event_hs) state_d = IDLE_s;
         default:     state_d = IDLE_s;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE_s;
         cqn_q      <= '0;
         offset_q   <= '0;
         base_q     <= '0;
         event_en_q <= 1'b0;
         cqe_q      <= '0;
         addr_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE_s && resp_hs) begin
            cqn_q    <= eng_io.cq_resp_head[CQ_NUM_LOG-1:0];
            offset_q <= eng_io.cq_resp_head[55:32];
         end
         if (state_q == LOOKUP_s) begin
            base_q     <= ctx_rd_q[63:0];
            event_en_q <= ctx_rd_q[64];
         end
         // 64-bit add wraps silently when the base sits near the top of memory.
         if (state_q == WAIT_DATA_s && data_hs) begin
            cqe_q  <= eng_io.cqe_data;
            addr_q <= base_q + {40'd0, offset_q};
         end
      end
   end

   always_comb begin
      eng_io.cq_resp_ready    = 1'b0;
      eng_io.cqe_data_ready   = 1'b0;
      eng_io.dma_wr_req_valid = 1'b0;
      eng_io.dma_wr_req_head  = '0;
      eng_io.dma_wr_req_data  = '0;
      eng_io.cq_event_valid   = 1'b0;
      eng_io.cq_event_cqn     = '0;
      case (state_q)
         IDLE_s:      eng_io.cq_resp_ready = 1'b1;
         WAIT_DATA_s: eng_io.cqe_data_ready = 1'b1;
         DMA_s: begin
            eng_io.dma_wr_req_valid = 1'b1;
            eng_io.dma_wr_req_head  = {32'd0, 32'(CQE_LENGTH), addr_q};
            eng_io.dma_wr_req_data  = cqe_q;
         end
         EVENT_s: begin
            eng_io.cq_event_valid = 1'b1;
            eng_io.cq_event_cqn   = cqn_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cqe_write_engine.sv
// Self-checking bench for cqe_write_engine: DMA writes and events are compared
// against expected queues filled when the matching stimulus is driven.
module tb_cqe_write_engine;
   logic clk;
   logic rst;
   logic [2:0] state_o;

   cqe_write_engine_if #(.CQ_NUM_LOG(12), .CQE_WIDTH(256)) bus ();

   cqe_write_engine #(.CQ_NUM_LOG(12), .CQE_LENGTH(32), .CQE_WIDTH(256)) dut (
      .clk     (clk),
      .rst     (rst),
      .eng_io  (bus),
      .state_o (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_dma    = 0;
   int n_event  = 0;

   logic [63:0]  exp_addr_q[$];
   logic [255:0] exp_data_q[$];
   logic [11:0]  exp_ev_q[$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctx_write(input logic [11:0] idx, input logic ev, input logic [63:0] base);
      bus.ctx_wr_en   = 1'b1;
      bus.ctx_wr_cqn  = idx;
      bus.ctx_wr_data = {ev, base};
      step();
      bus.ctx_wr_en   = 1'b0;
      bus.ctx_wr_cqn  = '0;
      bus.ctx_wr_data = '0;
   endtask

   task automatic expect_cqe(input logic [63:0] addr, input logic [255:0] data,
                             input logic ev, input logic [11:0] cqn);
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(data);
      if (ev) exp_ev_q.push_back(cqn);
   endtask

   task automatic send_resp(input logic [31:0] cqn, input logic [23:0] off);
      logic ok;
      ok = 1'b0;
      bus.cq_resp_valid = 1'b1;
      bus.cq_resp_head  = {off, cqn};
      for (int i = 0; i < 200; i++) begin
         ok = bus.cq_resp_ready;
         step();
         if (ok) break;
      end
      if (!ok) check("resp_timeout", 0, 1);
      bus.cq_resp_valid = 1'b0;
      bus.cq_resp_head  = '0;
   endtask

   task automatic send_cqe(input logic [255:0] data);
      logic ok;
      ok = 1'b0;
      bus.cqe_data_valid = 1'b1;
      bus.cqe_data       = data;
      for (int i = 0; i < 200; i++) begin
         ok = bus.cqe_data_ready;
         step();
         if (ok) break;
      end
      if (!ok) check("cqe_timeout", 0, 1);
      bus.cqe_data_valid = 1'b0;
      bus.cqe_data       = '0;
   endtask

   task automatic wait_drained();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (state_o == 3'd0 && exp_addr_q.size() == 0 && exp_ev_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      if (!done) check("drain_timeout", 0, 1);
   endtask

   // scoreboard monitor: samples on the falling edge, between active edges
   logic         dma_pend, ev_pend;
   logic [127:0] dma_head_hold;
   logic [255:0] dma_data_hold;
   logic [11:0]  ev_cqn_hold;

   always @(negedge clk) begin
      if (rst) begin
         dma_pend = 1'b0;
         ev_pend  = 1'b0;
      end else begin
         if (bus.dma_wr_req_valid) begin
            if (dma_pend) begin
               check("dma_head_stable", bus.dma_wr_req_head, dma_head_hold);
               check("dma_data_stable", bus.dma_wr_req_data, dma_data_hold);
            end
            if (bus.dma_wr_req_ready) begin
               n_dma++;
               dma_pend = 1'b0;
               if (exp_addr_q.size() == 0) begin
                  check("dma_unexpected", 1, 0);
               end else begin
                  check("dma_addr", bus.dma_wr_req_head[63:0], exp_addr_q.pop_front());
                  check("dma_len", bus.dma_wr_req_head[95:64], 32);
                  check("dma_head_hi", bus.dma_wr_req_head[127:96], 0);
                  check("dma_data", bus.dma_wr_req_data, exp_data_q.pop_front());
               end
            end else begin
               dma_pend      = 1'b1;
               dma_head_hold = bus.dma_wr_req_head;
               dma_data_hold = bus.dma_wr_req_data;
            end
         end else begin
            dma_pend = 1'b0;
         end
         if (bus.cq_event_valid) begin
            if (ev_pend) check("event_cqn_stable", bus.cq_event_cqn, ev_cqn_hold);
            if (bus.cq_event_ready) begin
               n_event++;
               ev_pend = 1'b0;
               if (exp_ev_q.size() == 0) check("event_unexpected", 1, 0);
               else check("event_cqn", bus.cq_event_cqn, exp_ev_q.pop_front());
            end else begin
               ev_pend     = 1'b1;
               ev_cqn_hold = bus.cq_event_cqn;
            end
         end else begin
            ev_pend = 1'b0;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_resp_ready"}, bus.cq_resp_ready, 1);
      check({tag, "_cqe_ready"}, bus.cqe_data_ready, 0);
      check({tag, "_dma_valid"}, bus.dma_wr_req_valid, 0);
      check({tag, "_dma_head"}, bus.dma_wr_req_head, 0);
      check({tag, "_dma_data"}, bus.dma_wr_req_data, 0);
      check({tag, "_ev_valid"}, bus.cq_event_valid, 0);
      check({tag, "_ev_cqn"}, bus.cq_event_cqn, 0);
      check({tag, "_state"}, state_o, 0);
   endtask

   logic [255:0] pat [1:3];
   int dma_before;

   initial begin
      rst                  = 1'b1;
      bus.cq_resp_valid    = 1'b0;
      bus.cq_resp_head     = '0;
      bus.cqe_data_valid   = 1'b0;
      bus.cqe_data         = '0;
      bus.ctx_wr_en        = 1'b0;
      bus.ctx_wr_cqn       = '0;
      bus.ctx_wr_data      = '0;
      bus.dma_wr_req_ready = 1'b0;
      bus.cq_event_ready   = 1'b0;
      repeat (3) step();
      check_idle_outputs("reset");
      rst = 1'b0;
      step();

      // basic: event enabled, CQE waiting ahead of its response
      ctx_write(12'd5, 1'b1, 64'h0000_0001_0000_0000);
      bus.dma_wr_req_ready = 1'b1;
      bus.cq_event_ready   = 1'b1;
      bus.cqe_data_valid   = 1'b1;
      bus.cqe_data         = {32{8'hA5}};
      check("early_cqe_ready", bus.cqe_data_ready, 0);
      bus.cq_resp_valid    = 1'b1;
      bus.cq_resp_head     = {24'h40, 32'd5};
      expect_cqe(64'h1_0000_0040, {32{8'hA5}}, 1'b1, 12'd5);
      step();
      bus.cq_resp_valid = 1'b0;
      bus.cq_resp_head  = '0;
      check("basic_t1_resp_ready", bus.cq_resp_ready, 0);
      check("basic_t1_cqe_ready", bus.cqe_data_ready, 0);
      step();
      check("basic_t2_cqe_ready", bus.cqe_data_ready, 1);
      step();
      bus.cqe_data_valid = 1'b0;
      bus.cqe_data       = '0;
      check("basic_t3_dma_valid", bus.dma_wr_req_valid, 1);
      check("basic_t3_dma_addr", bus.dma_wr_req_head[63:0], 64'h1_0000_0040);
      step();
      check("basic_t4_ev_valid", bus.cq_event_valid, 1);
      check("basic_t4_ev_cqn", bus.cq_event_cqn, 5);
      check("basic_t4_resp_ready", bus.cq_resp_ready, 0);
      step();
      check("basic_t5_resp_ready", bus.cq_resp_ready, 1);

      // event disabled
      ctx_write(12'd7, 1'b0, 64'h2000);
      bus.cqe_data_valid = 1'b1;
      bus.cqe_data       = {32{8'h5A}};
      bus.cq_resp_valid  = 1'b1;
      bus.cq_resp_head   = {24'h0, 32'd7};
      expect_cqe(64'h2000, {32{8'h5A}}, 1'b0, 12'd7);
      step();
      bus.cq_resp_valid = 1'b0;
      bus.cq_resp_head  = '0;
      step();
      step();
      bus.cqe_data_valid = 1'b0;
      bus.cqe_data       = '0;
      check("noev_t3_dma_valid", bus.dma_wr_req_valid, 1);
      step();
      check("noev_t4_resp_ready", bus.cq_resp_ready, 1);
      check("noev_t4_ev_valid", bus.cq_event_valid, 0);
      check("noev_t4_state", state_o, 0);

      // late data and DMA / event backpressure
      ctx_write(12'd9, 1'b1, 64'h3000_0000);
      bus.dma_wr_req_ready = 1'b0;
      bus.cq_event_ready   = 1'b0;
      pat[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expect_cqe(64'h3000_0100, pat[1], 1'b1, 12'd9);
      send_resp(32'd9, 24'h100);
      check("late_lookup_cqe_ready", bus.cqe_data_ready, 0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("late_wait_cqe_ready", bus.cqe_data_ready, 1);
      end
      bus.cqe_data_valid = 1'b1;
      bus.cqe_data       = pat[1];
      step();
      bus.cqe_data_valid = 1'b0;
      bus.cqe_data       = '0;
      for (int k = 0; k < 3; k++) begin
         check("bp_dma_valid", bus.dma_wr_req_valid, 1);
         check("bp_cqe_ready", bus.cqe_data_ready, 0);
         step();
      end
      dma_before = n_dma;
      bus.dma_wr_req_ready = 1'b1;
      step();
      check("bp_dma_accepts", n_dma - dma_before, 1);
      check("bp_ev_valid", bus.cq_event_valid, 1);
      step();
      step();
      bus.cq_event_ready = 1'b1;
      step();
      check("bp_resp_ready", bus.cq_resp_ready, 1);

      // wrap and CQN truncation
      ctx_write(12'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0);
      pat[2] = {8{$urandom}};
      expect_cqe(64'h10, pat[2], 1'b0, 12'd0);
      fork
         send_resp(32'h0000_1000, 24'h20);
         send_cqe(pat[2]);
      join
      wait_drained();

      // back-to-back, event on cqn 2 only
      ctx_write(12'd1, 1'b0, 64'h1000_0000);
      ctx_write(12'd2, 1'b1, 64'h2000_0000);
      ctx_write(12'd3, 1'b0, 64'h3000_0000);
      for (int i = 1; i <= 3; i++) begin
         pat[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         expect_cqe(64'(i) * 64'h1000_0000 + 64'((i - 1) * 32), pat[i], i == 2, 12'(i));
      end
      dma_before = n_event;
      fork
         for (int i = 1; i <= 3; i++) send_resp(32'(i), 24'((i - 1) * 32));
         for (int j = 1; j <= 3; j++) begin
            repeat ($urandom_range(0, 3)) step();
            send_cqe(pat[j]);
         end
      join
      wait_drained();
      check("b2b_event_count", n_event - dma_before, 1);

      // reset while a DMA is held off
      ctx_write(12'd4, 1'b1, 64'h4000);
      bus.dma_wr_req_ready = 1'b0;
      send_resp(32'd4, 24'h60);
      send_cqe({16{16'hBEEF}});
      check("rst_pre_dma_valid", bus.dma_wr_req_valid, 1);
      dma_before = n_dma;
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      step();
      rst = 1'b0;
      bus.dma_wr_req_ready = 1'b1;
      repeat (6) step();
      check("rst_no_dma_accept", n_dma - dma_before, 0);
      check("rst_after_dma_valid", bus.dma_wr_req_valid, 0);
      check("rst_after_resp_ready", bus.cq_resp_ready, 1);

      // recovery after reset
      pat[3] = {8{$urandom}};
      expect_cqe(64'h4060, pat[3], 1'b1, 12'd4);
      fork
         send_resp(32'd4, 24'h60);
         send_cqe(pat[3]);
      join
      wait_drained();

      check("total_dma", n_dma, 8);
      check("total_event", n_event, 4);
      check("exp_queue_empty", exp_addr_q.size() + exp_ev_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
